// File: rtl/anticoinc_cfg_loader_if.sv
// AXI4-Lite bundle between the anticoincidence config loader
// and the trigger slave's S00_AXI port.
interface anticoinc_cfg_loader_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/anticoinc_cfg_loader.sv
// Writes the four anticoincidence trigger control registers over
// AXI4-Lite, reads each back and reports pass/fail status.
module anticoinc_cfg_loader #(
    parameter int                      C_ADDR_WIDTH = 32,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = '0,
    parameter int                      C_TIMEOUT    = 255
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic                   start,
    input  logic [127:0]           cfg_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [1:0]             err_code,
    output logic [1:0]             err_index,
    anticoinc_cfg_loader_if.master m_axi
);
    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        FINISH
    } state_t;

    localparam logic [1:0] E_NONE     = 2'b00;
    localparam logic [1:0] E_MISMATCH = 2'b01;
    localparam logic [1:0] E_SLVERR   = 2'b10;
    localparam logic [1:0] E_TIMEOUT  = 2'b11;
    localparam logic [7:0] TMO_LAST   = 8'(C_TIMEOUT - 1);

    function automatic logic [C_ADDR_WIDTH-1:0] reg_addr(
        input logic [1:0] idx
    );
        return C_BASE_ADDR +
            {{(C_ADDR_WIDTH-4){1'b0}}, idx, 2'b00};
    endfunction

    function automatic logic [31:0] word_of(
        input logic [127:0] c,
        input logic [1:0]   idx
    );
        return c[32*idx +: 32];
    endfunction

    state_t                  state;
    state_t                  nxt_state;
    logic [1:0]              k;
    logic [1:0]              nxt_k;
    logic [127:0]            cfg;
    logic [127:0]            nxt_cfg;
    logic [7:0]              tcnt;
    logic [7:0]              nxt_tcnt;
    logic                    awvalid;
    logic                    nxt_awvalid;
    logic                    wvalid;
    logic                    nxt_wvalid;
    logic                    bready;
    logic                    nxt_bready;
    logic                    arvalid;
    logic                    nxt_arvalid;
    logic                    rready;
    logic                    nxt_rready;
    logic [C_ADDR_WIDTH-1:0] awaddr;
    logic [C_ADDR_WIDTH-1:0] nxt_awaddr;
    logic [C_ADDR_WIDTH-1:0] araddr;
    logic [C_ADDR_WIDTH-1:0] nxt_araddr;
    logic [31:0]             wdata;
    logic [31:0]             nxt_wdata;
    logic                    nxt_busy;
    logic                    nxt_done;
    logic                    nxt_error;
    logic [1:0]              nxt_err_code;
    logic [1:0]              nxt_err_index;

    logic                    aw_ok;
    logic                    w_ok;
    logic                    pending;
    logic                    fail;
    logic [1:0]              fail_code;
    logic                    unused_resp;

    // A channel is complete once its VALID has dropped or it
    // handshakes this cycle; AW and W may finish in any order.
    assign aw_ok = !awvalid || m_axi.awready;
    assign w_ok  = !wvalid  || m_axi.wready;

    assign unused_resp = ^{m_axi.bresp[0], m_axi.rresp[0]};

    assign m_axi.awaddr  = awaddr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid;
    assign m_axi.wdata   = wdata;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = wvalid;
    assign m_axi.bready  = bready;
    assign m_axi.araddr  = araddr;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid;
    assign m_axi.rready  = rready;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            k         <= '0;
            cfg       <= '0;
            tcnt      <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= C_BASE_ADDR;
            araddr    <= C_BASE_ADDR;
            wdata     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= E_NONE;
            err_index <= '0;
        end else begin
            state     <= nxt_state;
            k         <= nxt_k;
            cfg       <= nxt_cfg;
            tcnt      <= nxt_tcnt;
            awvalid   <= nxt_awvalid;
            wvalid    <= nxt_wvalid;
            bready    <= nxt_bready;
            arvalid   <= nxt_arvalid;
            rready    <= nxt_rready;
            awaddr    <= nxt_awaddr;
            araddr    <= nxt_araddr;
            wdata     <= nxt_wdata;
            busy      <= nxt_busy;
            done      <= nxt_done;
            error     <= nxt_error;
            err_code  <= nxt_err_code;
            err_index <= nxt_err_index;
        end
    end

    always_comb begin
        nxt_state     = state;
        nxt_k         = k;
        nxt_cfg       = cfg;
        nxt_tcnt      = '0;
        nxt_awvalid   = awvalid;
        nxt_wvalid    = wvalid;
        nxt_bready    = bready;
        nxt_arvalid   = arvalid;
        nxt_rready    = rready;
        nxt_awaddr    = awaddr;
        nxt_araddr    = araddr;
        nxt_wdata     = wdata;
        nxt_busy      = busy;
        nxt_done      = 1'b0;
        nxt_error     = error;
        nxt_err_code  = err_code;
        nxt_err_index = err_index;
        pending       = 1'b0;
        fail          = 1'b0;
        fail_code     = E_NONE;

        unique case (state)
            IDLE: begin
                if (start) begin
                    nxt_cfg       = cfg_data;
                    nxt_k         = '0;
                    nxt_error     = 1'b0;
                    nxt_err_code  = E_NONE;
                    nxt_err_index = '0;
                    nxt_awvalid   = 1'b1;
                    nxt_wvalid    = 1'b1;
                    nxt_awaddr    = reg_addr(2'd0);
                    nxt_wdata     = cfg_data[31:0];
                    nxt_busy      = 1'b1;
                    nxt_state     = WR_REQ;
                end
            end
            WR_REQ: begin
                if (aw_ok && w_ok) begin
                    nxt_awvalid = 1'b0;
                    nxt_wvalid  = 1'b0;
                    nxt_bready  = 1'b1;
                    nxt_state   = WR_RESP;
                end else begin
                    nxt_awvalid = awvalid && !m_axi.awready;
                    nxt_wvalid  = wvalid && !m_axi.wready;
                    pending     = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_axi.bvalid) begin
                    nxt_bready = 1'b0;
                    if (m_axi.bresp[1]) begin
                        fail      = 1'b1;
                        fail_code = E_SLVERR;
                    end else if (k == 2'd3) begin
                        nxt_k       = '0;
                        nxt_arvalid = 1'b1;
                        nxt_araddr  = reg_addr(2'd0);
                        nxt_state   = RD_REQ;
                    end else begin
                        nxt_k       = k + 2'd1;
                        nxt_awvalid = 1'b1;
                        nxt_wvalid  = 1'b1;
                        nxt_awaddr  = reg_addr(k + 2'd1);
                        nxt_wdata   = word_of(cfg, k + 2'd1);
                        nxt_state   = WR_REQ;
                    end
                end else begin
                    pending = 1'b1;
                end
            end
            RD_REQ: begin
                if (m_axi.arready) begin
                    nxt_arvalid = 1'b0;
                    nxt_rready  = 1'b1;
                    nxt_state   = RD_RESP;
                end else begin
                    pending = 1'b1;
                end
            end
            RD_RESP: begin
                if (m_axi.rvalid) begin
                    nxt_rready = 1'b0;
                    if (m_axi.rresp[1]) begin
                        fail      = 1'b1;
                        fail_code = E_SLVERR;
                    end else if (m_axi.rdata != word_of(cfg, k)) begin
                        fail      = 1'b1;
                        fail_code = E_MISMATCH;
                    end else if (k == 2'd3) begin
                        nxt_done  = 1'b1;
                        nxt_busy  = 1'b0;
                        nxt_state = FINISH;
                    end else begin
                        nxt_k       = k + 2'd1;
                        nxt_arvalid = 1'b1;
                        nxt_araddr  = reg_addr(k + 2'd1);
                        nxt_state   = RD_REQ;
                    end
                end else begin
                    pending = 1'b1;
                end
            end
            FINISH: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase

        // Handshake checks above win, so a late response still counts.
        if (pending) begin
            if (tcnt == TMO_LAST) begin
                fail      = 1'b1;
                fail_code = E_TIMEOUT;
            end else begin
                nxt_tcnt = tcnt + 8'd1;
            end
        end

        if (fail) begin
            nxt_error     = 1'b1;
            nxt_err_code  = fail_code;
            nxt_err_index = k;
            nxt_awvalid   = 1'b0;
            nxt_wvalid    = 1'b0;
            nxt_bready    = 1'b0;
            nxt_arvalid   = 1'b0;
            nxt_rready    = 1'b0;
            nxt_tcnt      = '0;
            nxt_done      = 1'b1;
            nxt_busy      = 1'b0;
            nxt_state     = FINISH;
        end
    end
endmodule

// File: tb/tb_anticoinc_cfg_loader.sv
// Scoreboard bench for anticoinc_cfg_loader with a configurable
// AXI4-Lite slave model.
module tb_anticoinc_cfg_loader;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic       err;
        logic [1:0] code;
        logic [1:0] idx;
        int         lat;
        int         bcnt;
        int         acnt;
    } st_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] cfg_data;
    logic         busy;
    logic         done;
    logic         error;
    logic [1:0]   err_code;
    logic [1:0]   err_index;

    always #5 clk = ~clk;

    anticoinc_cfg_loader_if #(.ADDR_WIDTH(32)) axi ();

    anticoinc_cfg_loader #(
        .C_ADDR_WIDTH(32),
        .C_BASE_ADDR (32'h0000_0000),
        .C_TIMEOUT   (8)
    ) dut (
        .ACLK     (clk),
        .ARESETN  (rst_n),
        .start    (start),
        .cfg_data (cfg_data),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_code (err_code),
        .err_index(err_index),
        .m_axi    (axi)
    );

    int checks   = 0;
    int failures = 0;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    st_t         exp_st[$];

    int aw_delay = 0;
    int bad_b    = -1;
    int bad_r    = -1;
    bit ar_stuck = 1'b0;

    task automatic chk(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave model: decides readies/responses on the falling edge,
    // so the handshakes flagged here occur at the next rising edge.
    initial begin : slave
        logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic        got_aw, got_w;
        logic [31:0] cap_aw, cap_w, cap_ar;
        logic [31:0] mem [4];
        int          aw_wait;
        wr_t         e;
        logic [31:0] ea;
        {aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
        {got_aw, got_w} = '0;
        cap_aw = '0;
        cap_w  = '0;
        cap_ar = '0;
        aw_wait = 0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rresp   = 2'b00;
        axi.rdata   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                {aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
                {got_aw, got_w} = '0;
                aw_wait     = 0;
                axi.awready = 1'b0;
                axi.wready  = 1'b0;
                axi.bvalid  = 1'b0;
                axi.arready = 1'b0;
                axi.rvalid  = 1'b0;
                continue;
            end
            if (aw_hs) got_aw = 1'b1;
            if (w_hs) got_w = 1'b1;
            if (b_hs) axi.bvalid = 1'b0;
            if (r_hs) axi.rvalid = 1'b0;
            if (got_aw && got_w) begin
                got_aw = 1'b0;
                got_w  = 1'b0;
                chk("wr_avail", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", cap_aw, e.addr);
                    chk("wr_data", cap_w, e.data);
                end
                mem[cap_aw[3:2]] = cap_w;
                axi.bvalid = 1'b1;
                axi.bresp  = (int'(cap_aw) == bad_b) ? 2'b10 : 2'b00;
            end
            if (ar_hs) begin
                chk("rd_avail", exp_rd.size() > 0, 1);
                if (exp_rd.size() > 0) begin
                    ea = exp_rd.pop_front();
                    chk("rd_addr", cap_ar, ea);
                end
                axi.rvalid = 1'b1;
                axi.rresp  = 2'b00;
                axi.rdata  = (int'(cap_ar) == bad_r) ?
                             32'hDEAD_0003 : mem[cap_ar[3:2]];
            end
            if (got_w && !got_aw) begin
                chk("w_drop", axi.wvalid, 0);
                chk("aw_hold", axi.awvalid, 1);
            end
            axi.awready = axi.awvalid && (aw_wait >= aw_delay);
            if (axi.awvalid && !axi.awready) aw_wait++;
            axi.wready  = axi.wvalid;
            axi.arready = axi.arvalid && !ar_stuck;
            aw_hs = axi.awvalid && axi.awready;
            w_hs  = axi.wvalid && axi.wready;
            b_hs  = axi.bvalid && axi.bready;
            ar_hs = axi.arvalid && axi.arready;
            r_hs  = axi.rvalid && axi.rready;
            if (aw_hs) begin
                cap_aw  = axi.awaddr;
                aw_wait = 0;
            end
            if (w_hs) begin
                cap_w = axi.wdata;
                chk("wstrb", axi.wstrb, 4'hF);
            end
            if (ar_hs) begin
                cap_ar = axi.araddr;
                chk("prot", {axi.awprot, axi.arprot}, 0);
            end
        end
    end

    task automatic rst_vals();
        chk("rst_valid", {axi.awvalid, axi.wvalid, axi.bready,
                          axi.arvalid, axi.rready}, 0);
        chk("rst_addr", {axi.awaddr, axi.araddr}, 0);
        chk("rst_wdata", axi.wdata, 0);
        chk("rst_stat", {busy, done, error, err_code, err_index}, 0);
    endtask

    task automatic run_seq(
        input logic [127:0] cfg,
        input int           n_wr,
        input int           n_rd,
        input st_t          st,
        input bit           restart
    );
        int  cyc;
        int  bcnt;
        int  acnt;
        bit  seen;
        st_t e;
        for (int i = 0; i < n_wr; i++)
            exp_wr.push_back('{addr: 32'(4 * i), data: cfg[32*i +: 32]});
        for (int i = 0; i < n_rd; i++)
            exp_rd.push_back(32'(4 * i));
        exp_st.push_back(st);
        @(negedge clk);
        cfg_data = cfg;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_on", busy, 1);
        chk("err_clr", {error, err_code, err_index}, 0);
        cyc  = 1;
        bcnt = 0;
        acnt = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            if (done) begin
                seen = 1'b1;
                e = exp_st.pop_front();
                chk("st_err", error, e.err);
                chk("st_code", err_code, e.code);
                chk("st_idx", err_index, e.idx);
                chk("lat", cyc, e.lat);
                chk("busy_cnt", bcnt, e.bcnt);
                chk("arv_cnt", acnt, e.acnt);
                chk("wr_left", exp_wr.size(), 0);
                chk("rd_left", exp_rd.size(), 0);
                chk("busy_fin", busy, 0);
            end else begin
                if (busy) bcnt++;
                if (axi.arvalid) acnt++;
                start = restart && (cyc == 5);
                if (start) cfg_data = ~cfg;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [127:0] c;
        int           dcnt;
        bit           found;
        rst_n    = 1'b0;
        start    = 1'b0;
        cfg_data = '0;
        repeat (3) @(negedge clk);
        rst_vals();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        c = {32'h4, 32'h3, 32'h2, 32'h1};
        run_seq(c, 4, 4, st_t'{1'b0, 2'd0, 2'd0, 17, 16, 4}, 1'b0);

        aw_delay = 3;
        c = {32'hCAFE_0004, 32'h1234_5678, 32'h0F0F_F0F0, 32'hA5A5_0001};
        run_seq(c, 4, 4, st_t'{1'b0, 2'd0, 2'd0, 29, 28, 4}, 1'b1);
        aw_delay = 0;

        bad_r = 8;
        c = {32'h4, 32'h3, 32'h2, 32'h1};
        run_seq(c, 4, 3, st_t'{1'b1, 2'd1, 2'd2, 15, 14, 3}, 1'b0);
        bad_r = -1;

        bad_b = 4;
        c = {32'h44, 32'h33, 32'h22, 32'h11};
        run_seq(c, 2, 0, st_t'{1'b1, 2'd2, 2'd1, 5, 4, 0}, 1'b0);
        bad_b = -1;

        ar_stuck = 1'b1;
        c = {32'h8000_0000, 32'h0000_FFFF, 32'h7, 32'hFFFF_FFFF};
        run_seq(c, 4, 0, st_t'{1'b1, 2'd3, 2'd0, 17, 16, 8}, 1'b0);
        chk("arv_drop", axi.arvalid, 0);
        ar_stuck = 1'b0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_vals();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        c = {32'hD, 32'hC, 32'hB, 32'hA};
        for (int i = 0; i < 4; i++)
            exp_wr.push_back('{addr: 32'(4 * i), data: c[32*i +: 32]});
        cfg_data = c;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (axi.bready && axi.awaddr == 32'h8) found = 1'b1;
            else @(negedge clk);
        end
        chk("wr2_seen", found, 1);
        #1 rst_n = 1'b0;
        #1 rst_vals();
        exp_wr.delete();
        exp_rd.delete();
        dcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("no_done", dcnt, 0);

        c = {32'h0BAD_F00D, 32'h2222_2222, 32'h1111_1111, 32'h5555_AAAA};
        run_seq(c, 4, 4, st_t'{1'b0, 2'd0, 2'd0, 17, 16, 4}, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/anticoinc_cfg_loader.md
# anticoinc_cfg_loader

AXI4-Lite master that programs the four 32-bit control registers of the anticoincidence trigger slave from a parallel configuration word, then reads each register back and checks it. It sits between the TUBii control logic and the trigger's S00_AXI port, and replaces software-driven register setup at run start. Completion, readback mismatch, slave error responses and handshake timeouts are reported on status outputs.

## Interface
- C_BASE_ADDR, 32'h0000_0000: byte address of register 0; register k is at C_BASE_ADDR + 4k.
- C_ADDR_WIDTH, 32: M_AXI address width.
- C_TIMEOUT, 255: maximum cycles to wait on any single handshake (8-bit counter, 1..255).
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- cfg_data  in  128  registers 0..3 in bits [32k+31:32k]; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of a sequence, pass or fail.
- error  out  1  sticky; set on failure, cleared by the next accepted start.
- err_code  out  2  00 none, 01 readback mismatch, 10 SLVERR/DECERR, 11 timeout.
- err_index  out  2  index of the register that failed.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA(32)/WSTRB(4)/WVALID/WREADY, BRESP(2)/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA(32)/RRESP(2)/RVALID/RREADY: standard AXI4-Lite master. PROT is fixed at 3'b000 and WSTRB at 4'hF.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH. An index register k (2 bits) selects the active register.
- IDLE: when start=1, capture cfg_data, clear error/err_code/err_index, set k=0, and go to WR_REQ.
- WR_REQ: assert AWVALID and WVALID together, with AWADDR=C_BASE_ADDR+4k and WDATA=word k. Each VALID drops independently after its own handshake. Move to WR_RESP once both handshakes are complete, including when they complete in different cycles.
- WR_RESP: BREADY=1. On BVALID, if BRESP[1]=1, fail with code 10. Otherwise, if k=3, set k=0 and go to RD_REQ; else increment k and go to WR_REQ.
- RD_REQ: ARVALID=1 with ARADDR=C_BASE_ADDR+4k. On ARREADY, go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID, if RRESP[1]=1, fail with code 10. Else, if RDATA differs from word k, fail with code 01. Else, if k=3, go to FINISH; else increment k and go to RD_REQ.
- Fail: set error, err_code and err_index=k, then go to FINISH. The first failure aborts the sequence, so no further transactions are issued.
- Timeout: a counter clears on every state entry and increments while the current handshake is pending. Reaching C_TIMEOUT counts as a fail with code 11, and all VALID/READY outputs drop immediately. This is a fatal fault: the slave must be reset before reuse.
- FINISH: done=1 for one cycle, then go to IDLE. busy=0 in IDLE and FINISH.
- start while busy is ignored and not queued.

## Timing
- All outputs are registered. Reset values: every VALID/READY=0, AWADDR/ARADDR=C_BASE_ADDR, WDATA=0, busy=0, done=0, error=0, err_code=00, err_index=00, state IDLE, k=0.
- With start sampled at edge 0, AWVALID/WVALID are high in the cycle after edge 0.
- Test slave: always-ready, responds on the cycle after address acceptance. Against it, each transaction takes exactly 2 cycles, done is high in cycle 17 after start, and busy is high in cycles 1..16.
- If ARESETN is asserted mid-sequence, all outputs return to reset values asynchronously. No done pulse is issued and no partial state is kept.
- A BVALID or RVALID in the same cycle as a timeout expiry is accepted, and the timeout does not fire.

## Test plan
- Zero-wait slave, cfg_data={32'h4,32'h3,32'h2,32'h1} -> writes of 1,2,3,4 to 0x0,0x4,0x8,0xC, reads match, done in cycle 17, error=0.
- AWREADY delayed 3 cycles while WREADY is immediate -> WVALID drops after its handshake, AWVALID is held, exactly one write per address, and the sequence passes.
- Slave returns 32'hDEAD_0003 when reading 0x8 -> error=1, err_code=01, err_index=2, no read of 0xC, done pulses.
- BRESP=2'b10 on the write to 0x4 -> err_code=10, err_index=1, no further AW/W, done pulses.
- ARREADY held low with C_TIMEOUT=8 -> ARVALID drops after 8 cycles, err_code=11, err_index=0, done pulses.
- ARESETN pulsed low during WR_RESP of register 2, then a new start -> outputs at reset values, no done pulse, and the new sequence runs from register 0 and passes.
